multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle RV32I control FSM; drives the shared datapath (PC, IR, regfile, ALU, unified memory port).
//  Sequences FETCH/DECODE/EXEC/MEM/WB, waits on a memory ready handshake, resolves all six branch types.
//  Extends the single-cycle opcode decode with I-type ALU ops, sra/slt/sltu, lui/auipc/jalr, bus-timeout and illegal-instruction traps.
// PARAMETERS
//  ALU_CTRL_W   4   width of alu_ctrl
//  TIMEOUT_CYC  16  max wait cycles for mem_ready in FETCH/MEM; 0 disables timeout
// PORTS
//  clk          in   1           single clock, rising edge
//  rst          in   1           synchronous, active-high reset
//  instr        in   32          IR contents (valid from DECODE onward)
//  mem_ready    in   1           memory completes current mem_req this cycle
//  alu_zero     in   1           ALU result == 0
//  ir_write     out  1           load IR (and old_pc) from memory read data
//  pc_write     out  1           load PC from source chosen by pc_src
//  pc_src       out  2           0 PC+4, 1 ALU result, 2 ALU result & ~1 (jalr)
//  alu_src_a    out  2           0 rs1, 1 old_pc, 2 zero
//  alu_src_b    out  2           0 rs2, 1 imm, 2 const 4
//  imm_sel      out  3           0 I, 1 S, 2 B, 3 U, 4 J
//  alu_ctrl     out  ALU_CTRL_W  0 add,1 sub,2 and,3 or,4 xor,5 sll,6 srl,7 sra,8 slt,9 sltu,15 invalid
//  mem_req      out  1           memory access request; held until mem_ready
//  mem_we       out  1           write (store) when mem_req=1
//  addr_src     out  1           0 PC (fetch), 1 ALU-out register (data)
//  reg_write    out  1           regfile write strobe
//  wb_sel       out  2           0 ALU-out, 1 mem data, 2 old_pc+4
//  trap         out  1           sticky fault flag
//  trap_cause   out  2           0 none, 1 illegal instruction, 2 bus timeout
//  state_o      out  3           current FSM state (debug)
// BEHAVIOUR
//  - Reset: state=FETCH, timeout counter=0, trap=0, trap_cause=0; all strobes (ir_write, pc_write, mem_req, mem_we, reg_write)=0 in the reset cycle.
//  - States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5. Outputs Moore: current state + decoded instr.
//  - FETCH: mem_req=1, addr_src=0. On mem_ready: ir_write=1, pc_write=1 (pc_src=0) -> DECODE. Min fetch latency 1 cycle.
//  - DECODE (1 cycle): alu_src_a=1, alu_src_b=1, imm_sel=B, add -> branch target in ALU-out. Illegal opcode/funct -> TRAP(cause 1); else -> EXEC.
//  - EXEC:
//    R-type: rs1 op rs2 -> WB. OP-IMM: rs1 op imm(I) -> WB. srai/srli split on instr[30]; slli/srli/srai with instr[31:25] not in {0x00, 0x20 for srai} -> illegal.
//    LOAD/STORE: rs1+imm (I or S) -> MEM. LUI: zero+imm(U) -> WB. AUIPC: old_pc+imm(U) -> WB.
//    BRANCH: beq/bne use sub; blt/bge use slt; bltu/bgeu use sltu.
//      taken = beq:zero, bne:!zero, blt/bltu:!zero, bge/bgeu:zero.
//      If taken, pc_write=1, pc_src=1 (target from DECODE). -> FETCH.
//    JAL: old_pc+imm(J), pc_write pc_src=1 -> WB. JALR: rs1+imm(I), pc_write pc_src=2 -> WB.
//  - MEM: mem_req=1, addr_src=1, mem_we=store. On mem_ready: load -> WB, store -> FETCH. Only LW/SW legal (funct3=010).
//  - WB (1 cycle): reg_write=1. wb_sel: 1 for load, 2 for jal/jalr, else 0. -> FETCH.
//  - Timeout: counter clears on entering FETCH/MEM and increments each cycle mem_ready=0. If it reaches TIMEOUT_CYC -> TRAP(cause 2), mem_req drops next cycle.
//  - mem_ready arriving in the same cycle the counter hits the limit: completion wins, no trap.
//  - TRAP: all strobes 0, trap=1, holds until rst. Reset mid-access drops mem_req the next cycle and restarts at FETCH.
//  - rd=x0 writes still assert reg_write; the regfile discards them.
// STRUCTURE
//  - Package rv_ctrl_pkg: opcode constants, ALU_* codes, state enum, PC_SRC_*/WB_*/IMM_*/CAUSE_* encodings.
//  - Sub-module rv_instr_decoder (combinational): instr -> class, alu_ctrl, imm_sel, illegal.
//  - This module holds the FSM, timeout counter, trap regs and branch resolution.
// TESTING
//  - 0x002081B3 (add x3,x1,x2), mem_ready=1 always -> states 0,1,2,4,0; alu_ctrl=0 in EXEC; reg_write=1 exactly in WB, wb_sel=0.
//  - 0x00812283 (lw x5,8(x2)), mem_ready 3 cycles late in MEM -> mem_req held 4 cycles, addr_src=1, mem_we=0; then WB with wb_sel=1.
//  - 0x00208463 (beq x1,x2,+8): alu_zero=1 -> pc_write,pc_src=1 in EXEC; repeat with alu_zero=0 -> no pc_write, back to FETCH.
//  - 0x00512223 (sw x5,4(x2)) -> MEM with mem_we=1, then FETCH; reg_write never asserted.
//  - 0xFFFFFFFF -> TRAP after DECODE, trap_cause=1, strobes 0 for 20 cycles; rst=1 for 1 cycle -> FETCH, trap=0.
//  - mem_ready held 0 in FETCH (TIMEOUT_CYC=16) -> TRAP, cause 2, after 16 cycles. Ready on cycle 16 -> no trap. rst mid-MEM -> mem_req=0 next cycle.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg
//   Shared constants and types for the multi-cycle RV32I control unit.
//   Contents:
//     - RV32I opcode constants used by the decoder
//     - ALU operation codes driven on alu_ctrl
//     - Mux-select encodings for pc_src, alu_src_a, alu_src_b, imm_sel, addr_src, wb_sel
//     - Trap cause encodings
//     - FSM state enum and instruction-class enum
//     - branch_taken(): turns funct3 and the ALU zero flag into a taken decision
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SUB     = 4'd1;
  localparam logic [3:0] ALU_AND     = 4'd2;
  localparam logic [3:0] ALU_OR      = 4'd3;
  localparam logic [3:0] ALU_XOR     = 4'd4;
  localparam logic [3:0] ALU_SLL     = 4'd5;
  localparam logic [3:0] ALU_SRL     = 4'd6;
  localparam logic [3:0] ALU_SRA     = 4'd7;
  localparam logic [3:0] ALU_SLT     = 4'd8;
  localparam logic [3:0] ALU_SLTU    = 4'd9;
  localparam logic [3:0] ALU_INVALID = 4'd15;

  localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SRC_ALU   = 2'd1;
  localparam logic [1:0] PC_SRC_JALR  = 2'd2;

  localparam logic [1:0] SRC_A_RS1   = 2'd0;
  localparam logic [1:0] SRC_A_OLDPC = 2'd1;
  localparam logic [1:0] SRC_A_ZERO  = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic ADDR_PC   = 1'b0;
  localparam logic ADDR_DATA = 1'b1;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_REG,
    CLS_IMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_NONE
  } instr_class_e;

  // funct3[0] flips the sense of the test. For beq/bne the ALU subtracts, so
  // "equal" means zero. For the less-than family the ALU produces slt/sltu,
  // so "less than" means non-zero; that is why funct3[2] inverts the polarity.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic alu_zero);
    logic taken;
    if (funct3[2]) taken = (alu_zero == funct3[0]);
    else           taken = (alu_zero != funct3[0]);
    return taken;
  endfunction

endpackage

// File: rtl/rv_instr_decoder.sv
// rv_instr_decoder
//   Purely combinational RV32I decoder. It classifies the instruction held in
//   the IR and selects the ALU operation and immediate format that EXEC uses.
//   Only the base integer set is accepted, with LW/SW as the sole memory ops.
// Ports:
//   instr     in   32  IR contents
//   cls       out  4   instruction class (CLS_NONE when illegal)
//   alu_ctrl  out  4   ALU operation for EXEC (ALU_INVALID when illegal)
//   imm_sel   out  3   immediate format for EXEC
//   illegal   out  1   opcode/funct combination is not supported
module rv_instr_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_e cls,
  output logic [3:0]   alu_ctrl,
  output logic [2:0]   imm_sel,
  output logic         illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_reg_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register indices and immediate bits are consumed by the datapath, not by control.
  assign unused_reg_fields = ^{instr[24:15], instr[11:7]};

  // alt selects the funct7=0x20 variant (sub, sra).
  function automatic logic [3:0] funct3_to_alu(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    cls      = CLS_NONE;
    alu_ctrl = ALU_ADD;
    imm_sel  = IMM_I;
    illegal  = 1'b0;
    case (opcode)
      OPC_OP: begin
        cls      = CLS_REG;
        alu_ctrl = funct3_to_alu(funct3, funct7[5]);
        if (funct7 == F7_ALT) illegal = !((funct3 == 3'b000) || (funct3 == 3'b101));
        else                  illegal = (funct7 != F7_BASE);
      end
      OPC_OP_IMM: begin
        cls      = CLS_IMM;
        imm_sel  = IMM_I;
        // Only shifts carry a funct7 field; addi etc. use those bits as immediate.
        alu_ctrl = funct3_to_alu(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
        if (funct3 == 3'b001)      illegal = (funct7 != F7_BASE);
        else if (funct3 == 3'b101) illegal = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
      end
      OPC_LOAD: begin
        cls     = CLS_LOAD;
        imm_sel = IMM_I;
        illegal = (funct3 != 3'b010);
      end
      OPC_STORE: begin
        cls     = CLS_STORE;
        imm_sel = IMM_S;
        illegal = (funct3 != 3'b010);
      end
      OPC_BRANCH: begin
        cls     = CLS_BRANCH;
        imm_sel = IMM_B;
        case (funct3[2:1])
          2'b00:   alu_ctrl = ALU_SUB;
          2'b10:   alu_ctrl = ALU_SLT;
          2'b11:   alu_ctrl = ALU_SLTU;
          default: illegal  = 1'b1;
        endcase
      end
      OPC_LUI: begin
        cls     = CLS_LUI;
        imm_sel = IMM_U;
      end
      OPC_AUIPC: begin
        cls     = CLS_AUIPC;
        imm_sel = IMM_U;
      end
      OPC_JAL: begin
        cls     = CLS_JAL;
        imm_sel = IMM_J;
      end
      OPC_JALR: begin
        cls     = CLS_JALR;
        imm_sel = IMM_I;
        illegal = (funct3 != 3'b000);
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      cls      = CLS_NONE;
      alu_ctrl = ALU_INVALID;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) driving a
//   shared datapath with a single memory port. Memory accesses wait on
//   mem_ready, bounded by a timeout that raises a sticky bus-timeout trap.
//   Illegal instructions are caught in DECODE and raise a sticky trap.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   instr        IR contents (valid from DECODE onward)
//   mem_ready    memory completes the current request this cycle
//   alu_zero     ALU result is zero (branch resolution)
//   ir_write     latch IR/old_pc from memory read data
//   pc_write     load PC from pc_src
//   pc_src       0 PC+4, 1 ALU result, 2 ALU result & ~1
//   alu_src_a    0 rs1, 1 old_pc, 2 zero
//   alu_src_b    0 rs2, 1 imm, 2 const 4
//   imm_sel      0 I, 1 S, 2 B, 3 U, 4 J
//   alu_ctrl     ALU operation code
//   mem_req      memory request, held until mem_ready
//   mem_we       store when mem_req is set
//   addr_src     0 PC, 1 ALU-out register
//   reg_write    regfile write strobe
//   wb_sel       0 ALU-out, 1 memory data, 2 old_pc+4
//   trap         sticky fault flag
//   trap_cause   0 none, 1 illegal instruction, 2 bus timeout
//   state_o      current FSM state
module multicycle_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic                  mem_ready,
  input  logic                  alu_zero,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            imm_sel,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  addr_src,
  output logic                  reg_write,
  output logic [1:0]            wb_sel,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [2:0]            state_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         trap_q, trap_d;
  logic [1:0]   cause_q, cause_d;

  instr_class_e dec_cls;
  logic [3:0]   dec_alu;
  logic [2:0]   dec_imm;
  logic         dec_illegal;

  logic [3:0]   alu_op;
  logic         ir_write_raw, pc_write_raw, mem_req_raw, mem_we_raw, reg_write_raw;
  logic         is_store;
  logic         timeout_hit;

  rv_instr_decoder u_decoder (
    .instr    (instr),
    .cls      (dec_cls),
    .alu_ctrl (dec_alu),
    .imm_sel  (dec_imm),
    .illegal  (dec_illegal)
  );

  assign is_store = (dec_cls == CLS_STORE);

  // Fires on the last permitted wait cycle; a same-cycle mem_ready suppresses it.
  assign timeout_hit = (TIMEOUT_CYC != 0) && !mem_ready && (cnt_q == CNT_LAST);

  // Next-state, wait counter, trap capture and Moore/handshake outputs.
  // The counter defaults to zero so it is cleared whenever FETCH/MEM is entered.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    trap_d        = trap_q;
    cause_d       = cause_q;
    ir_write_raw  = 1'b0;
    pc_write_raw  = 1'b0;
    mem_req_raw   = 1'b0;
    mem_we_raw    = 1'b0;
    reg_write_raw = 1'b0;
    pc_src        = PC_SRC_PLUS4;
    alu_src_a     = SRC_A_RS1;
    alu_src_b     = SRC_B_RS2;
    imm_sel       = IMM_I;
    alu_op        = ALU_ADD;
    addr_src      = ADDR_PC;
    wb_sel        = WB_ALU;

    case (state_q)
      ST_FETCH: begin
        mem_req_raw = 1'b1;
        addr_src    = ADDR_PC;
        if (mem_ready) begin
          ir_write_raw = 1'b1;
          pc_write_raw = 1'b1;
          pc_src       = PC_SRC_PLUS4;
          state_d      = ST_DECODE;
        end else if (timeout_hit) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Branch target is precomputed here so EXEC can load it from ALU-out.
      ST_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        imm_sel   = IMM_B;
        alu_op    = ALU_ADD;
        if (dec_illegal) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        imm_sel = dec_imm;
        alu_op  = dec_alu;
        case (dec_cls)
          CLS_REG: begin
            state_d = ST_WB;
          end
          CLS_IMM: begin
            alu_src_b = SRC_B_IMM;
            state_d   = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_b = SRC_B_IMM;
            state_d   = ST_MEM;
          end
          CLS_LUI: begin
            alu_src_a = SRC_A_ZERO;
            alu_src_b = SRC_B_IMM;
            state_d   = ST_WB;
          end
          CLS_AUIPC: begin
            alu_src_a = SRC_A_OLDPC;
            alu_src_b = SRC_B_IMM;
            state_d   = ST_WB;
          end
          CLS_BRANCH: begin
            if (branch_taken(instr[14:12], alu_zero)) begin
              pc_write_raw = 1'b1;
              pc_src       = PC_SRC_ALU;
            end
            state_d = ST_FETCH;
          end
          CLS_JAL: begin
            alu_src_a    = SRC_A_OLDPC;
            alu_src_b    = SRC_B_IMM;
            pc_write_raw = 1'b1;
            pc_src       = PC_SRC_ALU;
            state_d      = ST_WB;
          end
          CLS_JALR: begin
            alu_src_b    = SRC_B_IMM;
            pc_write_raw = 1'b1;
            pc_src       = PC_SRC_JALR;
            state_d      = ST_WB;
          end
          default: begin
            state_d = ST_TRAP;
            trap_d  = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end

      ST_MEM: begin
        mem_req_raw = 1'b1;
        mem_we_raw  = is_store;
        addr_src    = ADDR_DATA;
        if (mem_ready) begin
          state_d = is_store ? ST_FETCH : ST_WB;
        end else if (timeout_hit) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WB: begin
        reg_write_raw = 1'b1;
        case (dec_cls)
          CLS_LOAD:          wb_sel = WB_MEM;
          CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
          default:           wb_sel = WB_ALU;
        endcase
        state_d = ST_FETCH;
      end

      ST_TRAP: begin
        state_d = ST_TRAP;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State, wait counter and sticky trap registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  // Strobes are suppressed while reset is asserted so an in-flight access is
  // abandoned immediately rather than completing against stale state.
  assign ir_write   = ir_write_raw  & ~rst;
  assign pc_write   = pc_write_raw  & ~rst;
  assign mem_req    = mem_req_raw   & ~rst;
  assign mem_we     = mem_we_raw    & ~rst;
  assign reg_write  = reg_write_raw & ~rst;
  assign alu_ctrl   = ALU_CTRL_W'(alu_op);
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit
//   Directed-vector bench for the multi-cycle control FSM. Each stimulus call
//   drives one cycle of inputs and queues the hand-computed expected outputs
//   for that cycle; an independent monitor pops and compares on the falling edge.
module tb_multicycle_control_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        alu_zero;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  imm_sel;
  logic [3:0]  alu_ctrl;
  logic        mem_req;
  logic        mem_we;
  logic        addr_src;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state_o;

  multicycle_control_unit #(
    .ALU_CTRL_W  (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .mem_ready  (mem_ready),
    .alu_zero   (alu_zero),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_sel    (imm_sel),
    .alu_ctrl   (alu_ctrl),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_src   (addr_src),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .trap       (trap),
    .trap_cause (trap_cause),
    .state_o    (state_o)
  );

  // Observed vector layout (lsb first): imm_sel[2:0], alu_src_b[4:3],
  // alu_src_a[6:5], alu_ctrl[10:7], wb_sel[12:11], addr_src[13], pc_src[15:14],
  // trap_cause[17:16], trap[18], strobes {ir,pc,req,we,rw}[23:19], state[26:24].
  logic [26:0] obs;
  assign obs = {state_o, ir_write, pc_write, mem_req, mem_we, reg_write, trap, trap_cause,
                pc_src, addr_src, wb_sel, alu_ctrl, alu_src_a, alu_src_b, imm_sel};

  typedef struct {
    string       name;
    logic [26:0] val;
    logic [26:0] mask;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] I_ADD     = 32'h002081B3;
  localparam logic [31:0] I_LW      = 32'h00812283;
  localparam logic [31:0] I_BEQ     = 32'h00208463;
  localparam logic [31:0] I_BNE     = 32'h00209463;
  localparam logic [31:0] I_BLT     = 32'h0020C463;
  localparam logic [31:0] I_BGEU    = 32'h0020F463;
  localparam logic [31:0] I_SW      = 32'h00512223;
  localparam logic [31:0] I_JAL     = 32'h008000EF;
  localparam logic [31:0] I_JALR    = 32'h000080E7;
  localparam logic [31:0] I_SRAI    = 32'h4020D093;
  localparam logic [31:0] I_LUI     = 32'h123450B7;
  localparam logic [31:0] I_BADSLLI = 32'h40209093;
  localparam logic [31:0] I_ALLONES = 32'hFFFFFFFF;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A negative value marks the field as don't-care.
  function automatic exp_t put(input exp_t e, input int lsb, input int w, input int value);
    exp_t r;
    r = e;
    if (value >= 0) begin
      for (int i = 0; i < w; i++) begin
        r.val[lsb + i]  = value[i];
        r.mask[lsb + i] = 1'b1;
      end
    end
    return r;
  endfunction

  // One cycle of stimulus plus the expected outputs for that same cycle.
  task automatic applyStimulus(input string name, input logic rdy, input logic zr, input int st,
                               input logic [4:0] strb, input int trp, input int cse,
                               input int pcs, input int adr, input int wbs, input int alu,
                               input int asrc, input int bsrc, input int imm);
    exp_t e;
    mem_ready = rdy;
    alu_zero  = zr;
    e.name = name;
    e.val  = '0;
    e.mask = '0;
    e = put(e, 24, 3, st);
    e = put(e, 19, 5, int'(strb));
    e = put(e, 18, 1, trp);
    e = put(e, 16, 2, cse);
    e = put(e, 14, 2, pcs);
    e = put(e, 13, 1, adr);
    e = put(e, 11, 2, wbs);
    e = put(e,  7, 4, alu);
    e = put(e,  5, 2, asrc);
    e = put(e,  3, 2, bsrc);
    e = put(e,  0, 3, imm);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    total++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      bad++;
      $display("[TB] FAIL %s: got=%h required=%h (mask=%h, state=%0d)",
               e.name, obs & e.mask, e.val & e.mask, e.mask, state_o);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      checkOutput(mon_e);
    end
  end

  task automatic fetchOk(input string name);
    applyStimulus(name, 1'b1, 1'b0, 0, 5'b11100, 0, 0, 0, 0, -1, -1, -1, -1, -1);
  endtask

  task automatic decodeCyc(input string name);
    applyStimulus(name, 1'b0, 1'b0, 1, 5'b00000, 0, 0, -1, -1, -1, 0, 1, 1, 2);
  endtask

  task automatic wbCyc(input string name, input int wbs);
    applyStimulus(name, 1'b0, 1'b0, 4, 5'b00001, 0, 0, -1, -1, wbs, -1, -1, -1, -1);
  endtask

  task automatic branchCase(input string name, input logic [31:0] code, input logic zr,
                            input int alu, input logic taken);
    instr = code;
    fetchOk({name, " fetch"});
    decodeCyc({name, " decode"});
    applyStimulus({name, " exec"}, 1'b0, zr, 2, taken ? 5'b01000 : 5'b00000, 0, 0,
                  taken ? 1 : -1, -1, -1, alu, 0, 0, -1);
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b0;
    alu_zero  = 1'b0;
    instr     = 32'h0;
    @(posedge clk);
    #1;
    applyStimulus("reset cycle", 1'b0, 1'b0, 0, 5'b00000, 0, 0, -1, -1, -1, -1, -1, -1, -1);
    rst = 1'b0;

    instr = I_ADD;
    fetchOk("add fetch");
    decodeCyc("add decode");
    applyStimulus("add exec", 1'b0, 1'b0, 2, 5'b00000, 0, 0, -1, -1, -1, 0, 0, 0, -1);
    wbCyc("add wb", 0);

    instr = I_LW;
    fetchOk("lw fetch");
    decodeCyc("lw decode");
    applyStimulus("lw exec", 1'b0, 1'b0, 2, 5'b00000, 0, 0, -1, -1, -1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("lw mem wait", 1'b0, 1'b0, 3, 5'b00100, 0, 0, -1, 1, -1, -1, -1, -1, -1);
    applyStimulus("lw mem done", 1'b1, 1'b0, 3, 5'b00100, 0, 0, -1, 1, -1, -1, -1, -1, -1);
    wbCyc("lw wb", 1);

    branchCase("beq taken", I_BEQ, 1'b1, 1, 1'b1);
    branchCase("beq not taken", I_BEQ, 1'b0, 1, 1'b0);
    branchCase("bne taken", I_BNE, 1'b0, 1, 1'b1);
    branchCase("blt taken", I_BLT, 1'b0, 8, 1'b1);
    branchCase("bgeu not taken", I_BGEU, 1'b0, 9, 1'b0);

    instr = I_SW;
    fetchOk("sw fetch");
    decodeCyc("sw decode");
    applyStimulus("sw exec", 1'b0, 1'b0, 2, 5'b00000, 0, 0, -1, -1, -1, 0, 0, 1, 1);
    applyStimulus("sw mem", 1'b1, 1'b0, 3, 5'b00110, 0, 0, -1, 1, -1, -1, -1, -1, -1);

    instr = I_JAL;
    fetchOk("jal fetch after sw");
    decodeCyc("jal decode");
    applyStimulus("jal exec", 1'b0, 1'b0, 2, 5'b01000, 0, 0, 1, -1, -1, 0, 1, 1, 4);
    wbCyc("jal wb", 2);

    instr = I_JALR;
    fetchOk("jalr fetch");
    decodeCyc("jalr decode");
    applyStimulus("jalr exec", 1'b0, 1'b0, 2, 5'b01000, 0, 0, 2, -1, -1, 0, 0, 1, 0);
    wbCyc("jalr wb", 2);

    instr = I_SRAI;
    fetchOk("srai fetch");
    decodeCyc("srai decode");
    applyStimulus("srai exec", 1'b0, 1'b0, 2, 5'b00000, 0, 0, -1, -1, -1, 7, 0, 1, 0);
    wbCyc("srai wb", 0);

    instr = I_LUI;
    fetchOk("lui fetch");
    decodeCyc("lui decode");
    applyStimulus("lui exec", 1'b0, 1'b0, 2, 5'b00000, 0, 0, -1, -1, -1, 0, 2, 1, 3);
    wbCyc("lui wb", 0);

    instr = I_ALLONES;
    fetchOk("illegal fetch");
    decodeCyc("illegal decode");
    for (int i = 0; i < 20; i++)
      applyStimulus("illegal trap hold", 1'b0, 1'b0, 5, 5'b00000, 1, 1, -1, -1, -1, -1, -1, -1, -1);
    rst = 1'b1;
    applyStimulus("trap reset cycle", 1'b1, 1'b0, 5, 5'b00000, -1, -1, -1, -1, -1, -1, -1, -1, -1);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      applyStimulus("timeout fetch wait", 1'b0, 1'b0, 0, 5'b00100, 0, 0, -1, 0, -1, -1, -1, -1, -1);
    for (int i = 0; i < 2; i++)
      applyStimulus("timeout trap", 1'b0, 1'b0, 5, 5'b00000, 1, 2, -1, -1, -1, -1, -1, -1, -1);
    rst = 1'b1;
    applyStimulus("timeout reset cycle", 1'b0, 1'b0, 5, 5'b00000, -1, -1, -1, -1, -1, -1, -1, -1, -1);
    rst = 1'b0;

    instr = I_ADD;
    for (int i = 0; i < 15; i++)
      applyStimulus("late fetch wait", 1'b0, 1'b0, 0, 5'b00100, 0, 0, -1, 0, -1, -1, -1, -1, -1);
    fetchOk("ready on last cycle");
    decodeCyc("late add decode");
    applyStimulus("late add exec", 1'b0, 1'b0, 2, 5'b00000, 0, 0, -1, -1, -1, 0, 0, 0, -1);
    wbCyc("late add wb", 0);

    instr = I_LW;
    fetchOk("rst lw fetch");
    decodeCyc("rst lw decode");
    applyStimulus("rst lw exec", 1'b0, 1'b0, 2, 5'b00000, 0, 0, -1, -1, -1, 0, 0, 1, 0);
    applyStimulus("rst lw mem", 1'b0, 1'b0, 3, 5'b00100, 0, 0, -1, 1, -1, -1, -1, -1, -1);
    rst = 1'b1;
    applyStimulus("rst mid mem", 1'b0, 1'b0, 3, 5'b00000, 0, 0, -1, -1, -1, -1, -1, -1, -1);
    applyStimulus("rst held fetch", 1'b0, 1'b0, 0, 5'b00000, 0, 0, -1, -1, -1, -1, -1, -1, -1);
    rst = 1'b0;
    applyStimulus("restart fetch", 1'b0, 1'b0, 0, 5'b00100, 0, 0, -1, 0, -1, -1, -1, -1, -1);

    instr = I_BADSLLI;
    fetchOk("bad slli fetch");
    decodeCyc("bad slli decode");
    for (int i = 0; i < 2; i++)
      applyStimulus("bad slli trap", 1'b0, 1'b0, 5, 5'b00000, 1, 1, -1, -1, -1, -1, -1, -1, -1);

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard drain: got=%0d entries left required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
